uart_alu_engine: RTL and testbench
==================================

Name: uart_alu_engine

Overview:
Parametrised successor to the fixed-width UART ALU packet engine. Sits between the uart_rx AXI-Stream byte output and the uart_tx AXI-Stream byte input. Parses framed command packets, then either echoes the payload or reduces N operands of DataWidth bits with a selectable op (add/and/or/xor), and streams the result back LSB first. Adds a mid-packet timeout abort and single-byte resync on unknown opcodes.

Parameters:
DataWidth, 32, operand/result width in bits; multiple of 8, range 8..64
TimeoutCycles, 0, idle cycles between bytes inside a packet before abort; 0 disables the timeout
LenWidth, 16, width of the packet length field; fixed 16 for this protocol

Ports:
clk_i  in  1  clock
reset_ni  in  1  asynchronous active-low reset
s_axis_tdata  in  8  received byte from uart_rx
s_axis_tvalid  in  1  received byte valid
s_axis_tready  out  1  engine accepts the byte
m_axis_tdata  out  8  byte to uart_tx
m_axis_tvalid  out  1  output byte valid
m_axis_tready  in  1  uart_tx accepts the byte
busy_o  out  1  high whenever state != IDLE
abort_o  out  1  one-cycle pulse on timeout abort
err_opcode_o  out  1  one-cycle pulse on unknown opcode
acc_o  out  DataWidth  current accumulator value (debug/bench visibility)

Behaviour:
- Packet format: opcode, reserved byte (ignored), len_lo, len_hi. len = total bytes including the 4-byte header, little-endian.
- Opcodes: 0xEC echo; 0xAD add; 0xA1 and; 0xA2 or; 0xA3 xor.
- Reset (async, reset_ni=0): state IDLE. m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=0 during reset then 1 in IDLE. acc_o=0, busy_o=0, abort_o=0, err_opcode_o=0. Reset mid-packet discards all progress.
- States: IDLE -> RSVD -> LEN_LO -> LEN_HI -> {ECHO | ACC} -> (ACC only) RESULT -> IDLE.
- All transitions fire on an s_axis handshake, except RESULT exit and timeout.
- IDLE: unknown opcode pulses err_opcode_o next cycle and stays in IDLE; only that byte is dropped (resync).
- LEN_HI: remaining count = len-4. If len <= 4, go straight to IDLE with no output, including arithmetic ops.
- s_axis_tready:
  - 1 in IDLE, RSVD, LEN_LO, LEN_HI and ACC.
  - In ECHO: !m_axis_tvalid || m_axis_tready, giving a registered pass-through with no bubble.
  - 0 in RESULT.
- ECHO: each accepted byte appears on m_axis_tdata one cycle later. Return to IDLE after the last payload byte is accepted.
- ACC:
  - Bytes assemble LSB-first into an operand of DataWidth/8 bytes.
  - The first operand loads the accumulator; each later operand combines with it. Add wraps mod 2^DataWidth.
  - If the payload is not a multiple of DataWidth/8, the final partial operand is zero-extended and applied.
  - After the last byte, enter RESULT.
- RESULT: emit DataWidth/8 bytes, LSB first. Each byte is held stable with tvalid high until tready. Return to IDLE the cycle after the last handshake. m_axis_tvalid never drops without a handshake.
- Timeout (TimeoutCycles>0):
  - Counter clears on every accepted byte and runs in RSVD..ACC and ECHO.
  - On reaching TimeoutCycles: pulse abort_o, go to IDLE, no result emitted.
  - Any echo byte already in the output register still completes.
  - Counter does not run in IDLE or RESULT.
- Simultaneous events: timeout and byte arrival in the same cycle -> the byte wins and the counter clears.

Decomposition:
- uart_alu_pkg: opcode constants (OP_ECHO=8'hEC, OP_ADD=8'hAD, OP_AND=8'hA1, OP_OR=8'hA2, OP_XOR=8'hA3), state enum, header length constant 4.
- Sub-module uart_alu_ser: DataWidth-to-byte serializer with AXI-Stream handshake, used in RESULT.

Test Plan:
- Echo: EC 00 06 00 48 69 -> out 48, 69. Insert a 20-byte-time gap before 69 (TimeoutCycles=0) -> same output, busy_o high throughout.
- Resync: 00 48 EC 00 07 00 61 62 63 -> two err_opcode_o pulses, then out 61 62 63.
- Add: AD 00 0C 00 FF 02 4B 0D 21 43 65 87 -> acc_o 0x0D4B02FF after byte 8, then out 20 46 B0 94 (0x94B04620).
- Three-operand add: AD 00 10 00 01 00 00 00 AD DE 00 00 02 00 00 00 -> out B0 DE 00 00. Hold m_axis_tready low for 5 cycles mid-result -> data stable, no byte lost.
- Xor partial operand, DataWidth=16: A3 00 07 00 34 12 FF -> 0x1234^0x00FF -> out CB 12.
- Timeout: TimeoutCycles=100, send AD 00 08 00 01, then stall 200 cycles -> abort_o single pulse, no output. A following EC 00 05 00 5A gives out 5A. Also assert reset_ni low mid-packet -> outputs return to reset values immediately.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg
//   Shared definitions for the UART ALU packet engine: opcode values,
//   the packet-parser state encoding, the header length, and an opcode
//   validity helper.
`timescale 1ns/1ps
package uart_alu_pkg;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hAD;
    localparam logic [7:0] OP_AND  = 8'hA1;
    localparam logic [7:0] OP_OR   = 8'hA2;
    localparam logic [7:0] OP_XOR  = 8'hA3;

    // opcode, reserved, len_lo, len_hi
    localparam int HDR_LEN = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RSVD,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_ECHO,
        ST_ACC,
        ST_RESULT
    } state_t;

    function automatic logic isKnownOp(input logic [7:0] op);
        return (op == OP_ECHO) || (op == OP_ADD) || (op == OP_AND) ||
               (op == OP_OR)   || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/uart_alu_if.sv
// uart_alu_if
//   Byte-wide AXI-Stream link used on both sides of the engine.
//   Signals: tdata[7:0] byte, tvalid byte valid, tready sink accepts.
//   master modport drives tdata/tvalid, slave modport drives tready.
`timescale 1ns/1ps
interface uart_alu_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_alu_ser.sv
// uart_alu_ser
//   Loads a DataWidth-bit word and streams it out one byte at a time,
//   LSB first, with an AXI-Stream valid/ready handshake.
//   Ports:
//     clk_i, reset_ni : clock, asynchronous active-low reset
//     i_start, i_data : load the word to send (one-cycle strobe)
//     o_tdata, o_tvalid, i_tready : byte stream out
//     o_done          : high on the handshake of the last byte
`timescale 1ns/1ps
module uart_alu_ser #(
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 i_start,
    input  logic [DataWidth-1:0] i_data,
    output logic [7:0]           o_tdata,
    output logic                 o_tvalid,
    input  logic                 i_tready,
    output logic                 o_done
);

    localparam int NumBytes = DataWidth / 8;

    logic [DataWidth-1:0] r_shift;
    logic [3:0]           r_left;
    logic                 w_hs;

    assign o_tvalid = (r_left != 4'd0);
    assign o_tdata  = r_shift[7:0];
    assign w_hs     = o_tvalid && i_tready;
    assign o_done   = w_hs && (r_left == 4'd1);

    // The shift register empties to zero as bytes leave, so the idle
    // output byte is always 0.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_shift <= '0;
            r_left  <= 4'd0;
        end else if (i_start) begin
            r_shift <= i_data;
            r_left  <= 4'(NumBytes);
        end else if (w_hs) begin
            r_shift <= r_shift >> 8;
            r_left  <= r_left - 4'd1;
        end
    end

endmodule

// File: rtl/uart_alu_engine.sv
// uart_alu_engine
//   Parses framed command packets from a UART receive byte stream and
//   either echoes the payload or reduces it as DataWidth-bit operands with
//   add/and/or/xor, returning the result LSB first.
//   Ports:
//     clk_i, reset_ni : clock, asynchronous active-low reset
//     s_axis          : received bytes (slave)
//     m_axis          : bytes to transmit (master)
//     busy_o          : packet in progress (state not IDLE)
//     abort_o         : one-cycle pulse on inter-byte timeout abort
//     err_opcode_o    : one-cycle pulse when an unknown opcode is dropped
//     acc_o           : current accumulator value
`timescale 1ns/1ps
module uart_alu_engine
    import uart_alu_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 0,
    parameter int LenWidth      = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    uart_alu_if.slave            s_axis,
    uart_alu_if.master           m_axis,
    output logic                 busy_o,
    output logic                 abort_o,
    output logic                 err_opcode_o,
    output logic [DataWidth-1:0] acc_o
);

    localparam int          NumBytes = DataWidth / 8;
    localparam bit          ToEnable = (TimeoutCycles > 0);
    localparam logic [31:0] ToLast   = ToEnable ? 32'(TimeoutCycles - 1) : 32'd0;

    state_t               r_state, w_stateNext;
    logic [7:0]           r_op, r_lenLo;
    logic [LenWidth-1:0]  r_remain, w_len;
    logic [DataWidth-1:0] r_acc, r_operand, w_operandNext, w_accNext;
    logic [3:0]           r_byteIdx;
    logic                 r_firstOp;
    logic                 r_live;
    logic                 r_echoValid;
    logic [7:0]           r_echoData;
    logic [31:0]          r_toCnt;
    logic                 r_abort, r_errOp;

    logic       w_sReady, w_sHs, w_lastByte, w_opFull;
    logic       w_toRun, w_toFire;
    logic       w_serStart, w_serValid, w_serReady, w_serDone;
    logic [7:0] w_serData;

    function automatic logic [DataWidth-1:0] aluApply(
        input logic [7:0]           op,
        input logic [DataWidth-1:0] a,
        input logic [DataWidth-1:0] b
    );
        case (op)
            OP_ADD:  return a + b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            default: return a ^ b;
        endcase
    endfunction

    assign w_sHs      = s_axis.tvalid && w_sReady;
    assign w_len      = LenWidth'({s_axis.tdata, r_lenLo});
    assign w_lastByte = (r_remain == LenWidth'(1));

    // Payload bytes are OR-ed into place, so a short final operand is
    // naturally zero-extended.
    assign w_operandNext = r_operand | (DataWidth'(s_axis.tdata) << {r_byteIdx, 3'b000});
    assign w_opFull      = (r_byteIdx == 4'(NumBytes - 1)) || w_lastByte;
    assign w_accNext     = r_firstOp ? w_operandNext : aluApply(r_op, r_acc, w_operandNext);
    assign w_serStart    = (r_state == ST_ACC) && w_sHs && w_lastByte;

    // An arriving byte always beats an expiring timeout.
    assign w_toRun  = ToEnable && (r_state inside {ST_RSVD, ST_LEN_LO, ST_LEN_HI, ST_ECHO, ST_ACC});
    assign w_toFire = w_toRun && !w_sHs && (r_toCnt == ToLast);

    // r_live keeps tready low while reset is held and for the first edge after.
    always_comb begin
        w_sReady = 1'b0;
        case (r_state)
            ST_IDLE, ST_RSVD, ST_LEN_LO, ST_LEN_HI, ST_ACC: w_sReady = 1'b1;
            ST_ECHO: w_sReady = !r_echoValid || m_axis.tready;
            default: w_sReady = 1'b0;
        endcase
        w_sReady = w_sReady && r_live;
    end

    always_comb begin
        w_stateNext = r_state;
        if (w_toFire) begin
            w_stateNext = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (w_sHs && isKnownOp(s_axis.tdata)) w_stateNext = ST_RSVD;
                ST_RSVD:   if (w_sHs) w_stateNext = ST_LEN_LO;
                ST_LEN_LO: if (w_sHs) w_stateNext = ST_LEN_HI;
                ST_LEN_HI: begin
                    if (w_sHs) begin
                        if (w_len <= LenWidth'(HDR_LEN)) w_stateNext = ST_IDLE;
                        else if (r_op == OP_ECHO)        w_stateNext = ST_ECHO;
                        else                             w_stateNext = ST_ACC;
                    end
                end
                ST_ECHO:   if (w_sHs && w_lastByte) w_stateNext = ST_IDLE;
                ST_ACC:    if (w_sHs && w_lastByte) w_stateNext = ST_RESULT;
                ST_RESULT: if (w_serDone) w_stateNext = ST_IDLE;
                default:   w_stateNext = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) r_state <= ST_IDLE;
        else           r_state <= w_stateNext;
    end

    // The echo register lives outside the state machine so a byte already
    // captured still drains after a timeout abort.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_live      <= 1'b0;
            r_abort     <= 1'b0;
            r_errOp     <= 1'b0;
            r_toCnt     <= 32'd0;
            r_echoValid <= 1'b0;
            r_echoData  <= 8'd0;
            r_op        <= 8'd0;
            r_lenLo     <= 8'd0;
            r_remain    <= '0;
            r_operand   <= '0;
            r_byteIdx   <= 4'd0;
            r_firstOp   <= 1'b1;
            r_acc       <= '0;
        end else begin
            r_live  <= 1'b1;
            r_abort <= w_toFire;
            r_errOp <= (r_state == ST_IDLE) && w_sHs && !isKnownOp(s_axis.tdata);

            if (w_sHs || !w_toRun || w_toFire) r_toCnt <= 32'd0;
            else                               r_toCnt <= r_toCnt + 32'd1;

            if ((r_state == ST_ECHO) && w_sHs) begin
                r_echoValid <= 1'b1;
                r_echoData  <= s_axis.tdata;
            end else if (m_axis.tready) begin
                r_echoValid <= 1'b0;
            end

            case (r_state)
                ST_IDLE:   if (w_sHs) r_op <= s_axis.tdata;
                ST_LEN_LO: if (w_sHs) r_lenLo <= s_axis.tdata;
                ST_LEN_HI: begin
                    if (w_sHs) begin
                        r_remain  <= w_len - LenWidth'(HDR_LEN);
                        r_operand <= '0;
                        r_byteIdx <= 4'd0;
                        r_firstOp <= 1'b1;
                    end
                end
                ST_ECHO:   if (w_sHs) r_remain <= r_remain - LenWidth'(1);
                ST_ACC: begin
                    if (w_sHs) begin
                        r_remain <= r_remain - LenWidth'(1);
                        if (w_opFull) begin
                            r_acc     <= w_accNext;
                            r_operand <= '0;
                            r_byteIdx <= 4'd0;
                            r_firstOp <= 1'b0;
                        end else begin
                            r_operand <= w_operandNext;
                            r_byteIdx <= r_byteIdx + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    uart_alu_ser #(.DataWidth(DataWidth)) u_ser (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .i_start  (w_serStart),
        .i_data   (w_accNext),
        .o_tdata  (w_serData),
        .o_tvalid (w_serValid),
        .i_tready (w_serReady),
        .o_done   (w_serDone)
    );

    // A pending echo byte owns the output until it drains.
    assign w_serReady    = m_axis.tready && !r_echoValid;
    assign m_axis.tvalid = r_echoValid || w_serValid;
    assign m_axis.tdata  = r_echoValid ? r_echoData : w_serData;
    assign s_axis.tready = w_sReady;

    assign busy_o       = (r_state != ST_IDLE);
    assign abort_o      = r_abort;
    assign err_opcode_o = r_errOp;
    assign acc_o        = r_acc;

endmodule

// File: tb/tb_uart_alu_engine.sv
// tb_uart_alu_engine
//   Directed test of uart_alu_engine. dutMain is 32-bit with a 100-cycle
//   timeout; dut16 is 16-bit with no timeout. tgt selects which one
//   receives stimulus.
`timescale 1ns/1ps
module tb_uart_alu_engine;

    logic       clk_i    = 1'b0;
    logic       reset_ni = 1'b0;
    logic [7:0] sTdata   = 8'd0;
    logic       sTvalid  = 1'b0;
    logic       mTready  = 1'b1;
    int         tgt      = 0;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [7:0] outMain[$];
    logic [7:0] out16[$];
    logic [7:0] txQ[$];
    int errCntMain   = 0;
    int abortCntMain = 0;

    logic        busyMain, abortMain, errMain;
    logic [31:0] accMain;
    logic        busy16, abort16, err16;
    logic [15:0] acc16;

    uart_alu_if sMain();
    uart_alu_if mMain();
    uart_alu_if s16();
    uart_alu_if m16();

    assign sMain.tdata  = sTdata;
    assign sMain.tvalid = sTvalid && (tgt == 0);
    assign mMain.tready = mTready;
    assign s16.tdata    = sTdata;
    assign s16.tvalid   = sTvalid && (tgt == 1);
    assign m16.tready   = mTready;

    uart_alu_engine #(.DataWidth(32), .TimeoutCycles(100), .LenWidth(16)) dutMain (
        .clk_i(clk_i), .reset_ni(reset_ni), .s_axis(sMain), .m_axis(mMain),
        .busy_o(busyMain), .abort_o(abortMain), .err_opcode_o(errMain), .acc_o(accMain)
    );

    uart_alu_engine #(.DataWidth(16), .TimeoutCycles(0), .LenWidth(16)) dut16 (
        .clk_i(clk_i), .reset_ni(reset_ni), .s_axis(s16), .m_axis(m16),
        .busy_o(busy16), .abort_o(abort16), .err_opcode_o(err16), .acc_o(acc16)
    );

    always #5 clk_i = ~clk_i;

    // Inputs only change just after rising edges, so a valid&ready seen
    // at the falling edge is the handshake of the next rising edge.
    always @(negedge clk_i) begin
        if (mMain.tvalid && mMain.tready) outMain.push_back(mMain.tdata);
        if (m16.tvalid && m16.tready)     out16.push_back(m16.tdata);
        if (errMain)   errCntMain++;
        if (abortMain) abortCntMain++;
    end

    function automatic logic [7:0] qByte(input int sel, input int idx);
        if (sel == 0) return (idx < outMain.size()) ? outMain[idx] : 8'hxx;
        return (idx < out16.size()) ? out16[idx] : 8'hxx;
    endfunction

    task automatic sendByte(input logic [7:0] b);
        int   waitCnt;
        logic rdy;
        waitCnt = 0;
        sTdata  = b;
        sTvalid = 1'b1;
        @(negedge clk_i);
        rdy = (tgt == 0) ? sMain.tready : s16.tready;
        while (!rdy && waitCnt < 200) begin
            @(negedge clk_i);
            waitCnt++;
            rdy = (tgt == 0) ? sMain.tready : s16.tready;
        end
        if (!rdy) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL send_ready: byte %02h tready=%0b required 1", b, rdy);
        end
        @(posedge clk_i); #1;
        sTvalid = 1'b0;
    endtask

    task automatic sendAll();
        foreach (txQ[i]) sendByte(txQ[i]);
    endtask

    task automatic waitOut(input int n, input int budget);
        int c;
        c = 0;
        while ((((tgt == 0) ? outMain.size() : out16.size()) < n) && (c < budget)) begin
            @(posedge clk_i); #1;
            c++;
        end
        if (c >= budget) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL wait_out: got %0d bytes required %0d",
                     (tgt == 0) ? outMain.size() : out16.size(), n);
        end
        repeat (4) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        testsRun++;
        if (sMain.tready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_s_tready: got %0b required 0", sMain.tready); end
        testsRun++;
        if (mMain.tvalid !== 1'b0 || mMain.tdata !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_m_axis: tvalid=%0b tdata=%02h required 0/00", mMain.tvalid, mMain.tdata); end
        testsRun++;
        if (busyMain !== 1'b0 || abortMain !== 1'b0 || errMain !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_flags: busy=%0b abort=%0b err=%0b required 0", busyMain, abortMain, errMain); end
        testsRun++;
        if (accMain !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_acc: got %08h required 0", accMain); end
        @(posedge clk_i); #1;
        reset_ni = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        testsRun++;
        if (sMain.tready !== 1'b1) begin testsFailed++; $display("[TB] FAIL idle_s_tready: got %0b required 1", sMain.tready); end
    endtask

    task automatic test_echo();
        logic       busyOk;
        logic [7:0] exp [2];
        exp[0] = 8'h48;
        exp[1] = 8'h69;
        tgt = 0;
        outMain.delete();
        txQ = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h48};
        sendAll();
        busyOk = 1'b1;
        repeat (20) begin
            @(negedge clk_i);
            if (busyMain !== 1'b1) busyOk = 1'b0;
        end
        @(posedge clk_i); #1;
        sendByte(8'h69);
        waitOut(2, 50);
        testsRun++;
        if (busyOk !== 1'b1) begin testsFailed++; $display("[TB] FAIL echo_busy_gap: got %0b required 1", busyOk); end
        testsRun++;
        if (outMain.size() != 2) begin testsFailed++; $display("[TB] FAIL echo_count: got %0d required 2", outMain.size()); end
        for (int i = 0; i < 2; i++) begin
            testsRun++;
            if (qByte(0, i) !== exp[i]) begin testsFailed++; $display("[TB] FAIL echo_byte%0d: got %02h required %02h", i, qByte(0, i), exp[i]); end
        end
        testsRun++;
        if (busyMain !== 1'b0) begin testsFailed++; $display("[TB] FAIL echo_idle: busy=%0b required 0", busyMain); end
    endtask

    task automatic test_resync();
        int          errBase;
        logic [23:0] exp;
        exp = 24'h636261;
        tgt = 0;
        outMain.delete();
        errBase = errCntMain;
        txQ = '{8'h00, 8'h48, 8'hEC, 8'h00, 8'h07, 8'h00, 8'h61, 8'h62, 8'h63};
        sendAll();
        waitOut(3, 50);
        testsRun++;
        if (errCntMain - errBase != 2) begin testsFailed++; $display("[TB] FAIL resync_err_pulses: got %0d required 2", errCntMain - errBase); end
        testsRun++;
        if (outMain.size() != 3) begin testsFailed++; $display("[TB] FAIL resync_count: got %0d required 3", outMain.size()); end
        for (int i = 0; i < 3; i++) begin
            testsRun++;
            if (qByte(0, i) !== exp[8*i +: 8]) begin testsFailed++; $display("[TB] FAIL resync_byte%0d: got %02h required %02h", i, qByte(0, i), exp[8*i +: 8]); end
        end
    endtask

    task automatic test_add();
        logic [31:0] exp;
        exp = 32'h94B04620;
        tgt = 0;
        outMain.delete();
        txQ = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'h02, 8'h4B, 8'h0D};
        sendAll();
        testsRun++;
        if (accMain !== 32'h0D4B02FF) begin testsFailed++; $display("[TB] FAIL add_acc_first: got %08h required 0d4b02ff", accMain); end
        txQ = '{8'h21, 8'h43, 8'h65, 8'h87};
        sendAll();
        waitOut(4, 50);
        testsRun++;
        if (outMain.size() != 4) begin testsFailed++; $display("[TB] FAIL add_count: got %0d required 4", outMain.size()); end
        for (int i = 0; i < 4; i++) begin
            testsRun++;
            if (qByte(0, i) !== exp[8*i +: 8]) begin testsFailed++; $display("[TB] FAIL add_byte%0d: got %02h required %02h", i, qByte(0, i), exp[8*i +: 8]); end
        end
    endtask

    task automatic test_and_or();
        logic [31:0] expAnd, expOr;
        expAnd = 32'h0F0F3030;
        expOr  = 32'h88442211;
        tgt = 0;
        outMain.delete();
        txQ = '{8'hA1, 8'h00, 8'h0C, 8'h00, 8'hF0, 8'hF0, 8'hFF, 8'h0F, 8'h3C, 8'h3C, 8'h0F, 8'hFF};
        sendAll();
        waitOut(4, 50);
        for (int i = 0; i < 4; i++) begin
            testsRun++;
            if (qByte(0, i) !== expAnd[8*i +: 8]) begin testsFailed++; $display("[TB] FAIL and_byte%0d: got %02h required %02h", i, qByte(0, i), expAnd[8*i +: 8]); end
        end
        outMain.delete();
        txQ = '{8'hA2, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        sendAll();
        waitOut(4, 50);
        for (int i = 0; i < 4; i++) begin
            testsRun++;
            if (qByte(0, i) !== expOr[8*i +: 8]) begin testsFailed++; $display("[TB] FAIL or_byte%0d: got %02h required %02h", i, qByte(0, i), expOr[8*i +: 8]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        logic        holdOk;
        int          c;
        exp = 32'h0000DEB0;
        tgt = 0;
        outMain.delete();
        txQ = '{8'hAD, 8'h00, 8'h10, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                8'hAD, 8'hDE, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        sendAll();
        c = 0;
        while (outMain.size() < 1 && c < 50) begin @(posedge clk_i); #1; c++; end
        mTready = 1'b0;
        holdOk = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            if (mMain.tvalid !== 1'b1 || mMain.tdata !== 8'hDE || sMain.tready !== 1'b0) holdOk = 1'b0;
        end
        testsRun++;
        if (holdOk !== 1'b1) begin testsFailed++; $display("[TB] FAIL result_hold: tvalid=%0b tdata=%02h s_tready=%0b required 1/de/0", mMain.tvalid, mMain.tdata, sMain.tready); end
        @(posedge clk_i); #1;
        mTready = 1'b1;
        waitOut(4, 50);
        testsRun++;
        if (outMain.size() != 4) begin testsFailed++; $display("[TB] FAIL add3_count: got %0d required 4", outMain.size()); end
        for (int i = 0; i < 4; i++) begin
            testsRun++;
            if (qByte(0, i) !== exp[8*i +: 8]) begin testsFailed++; $display("[TB] FAIL add3_byte%0d: got %02h required %02h", i, qByte(0, i), exp[8*i +: 8]); end
        end
    endtask

    task automatic test_xor16();
        logic [15:0] exp;
        exp = 16'h12CB;
        tgt = 1;
        out16.delete();
        txQ = '{8'hA3, 8'h00, 8'h07, 8'h00, 8'h34, 8'h12, 8'hFF};
        sendAll();
        waitOut(2, 50);
        testsRun++;
        if (acc16 !== exp) begin testsFailed++; $display("[TB] FAIL xor16_acc: got %04h required %04h", acc16, exp); end
        testsRun++;
        if (out16.size() != 2) begin testsFailed++; $display("[TB] FAIL xor16_count: got %0d required 2", out16.size()); end
        for (int i = 0; i < 2; i++) begin
            testsRun++;
            if (qByte(1, i) !== exp[8*i +: 8]) begin testsFailed++; $display("[TB] FAIL xor16_byte%0d: got %02h required %02h", i, qByte(1, i), exp[8*i +: 8]); end
        end
        tgt = 0;
    endtask

    task automatic test_short_len();
        tgt = 0;
        outMain.delete();
        txQ = '{8'hAD, 8'h00, 8'h04, 8'h00};
        sendAll();
        repeat (10) @(posedge clk_i);
        #1;
        testsRun++;
        if (busyMain !== 1'b0) begin testsFailed++; $display("[TB] FAIL short_busy: got %0b required 0", busyMain); end
        testsRun++;
        if (outMain.size() != 0) begin testsFailed++; $display("[TB] FAIL short_output: got %0d bytes required 0", outMain.size()); end
    endtask

    task automatic test_timeout();
        int abortBase;
        tgt = 0;
        outMain.delete();
        abortBase = abortCntMain;
        txQ = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h01};
        sendAll();
        repeat (50) @(negedge clk_i);
        testsRun++;
        if (abortCntMain != abortBase || busyMain !== 1'b1) begin testsFailed++; $display("[TB] FAIL timeout_early: aborts=%0d busy=%0b required 0/1", abortCntMain - abortBase, busyMain); end
        repeat (150) @(negedge clk_i);
        testsRun++;
        if (abortCntMain - abortBase != 1) begin testsFailed++; $display("[TB] FAIL timeout_abort_pulse: got %0d required 1", abortCntMain - abortBase); end
        testsRun++;
        if (busyMain !== 1'b0 || outMain.size() != 0) begin testsFailed++; $display("[TB] FAIL timeout_state: busy=%0b bytes=%0d required 0/0", busyMain, outMain.size()); end
        @(posedge clk_i); #1;
        txQ = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
        sendAll();
        waitOut(1, 50);
        testsRun++;
        if (outMain.size() != 1 || qByte(0, 0) !== 8'h5A) begin testsFailed++; $display("[TB] FAIL timeout_recover: bytes=%0d first=%02h required 1/5a", outMain.size(), qByte(0, 0)); end
    endtask

    task automatic test_reset_mid();
        tgt = 0;
        outMain.delete();
        txQ = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h01};
        sendAll();
        reset_ni = 1'b0;
        #2;
        testsRun++;
        if (busyMain !== 1'b0 || accMain !== 32'd0) begin testsFailed++; $display("[TB] FAIL midreset_state: busy=%0b acc=%08h required 0/0", busyMain, accMain); end
        testsRun++;
        if (mMain.tvalid !== 1'b0 || mMain.tdata !== 8'h00 || sMain.tready !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_axis: m_tvalid=%0b m_tdata=%02h s_tready=%0b required 0/00/0", mMain.tvalid, mMain.tdata, sMain.tready); end
        @(posedge clk_i); #1;
        reset_ni = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        txQ = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h77};
        sendAll();
        waitOut(1, 50);
        testsRun++;
        if (outMain.size() != 1 || qByte(0, 0) !== 8'h77) begin testsFailed++; $display("[TB] FAIL midreset_recover: bytes=%0d first=%02h required 1/77", outMain.size(), qByte(0, 0)); end
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        test_reset();
        test_echo();
        test_resync();
        test_add();
        test_and_or();
        test_back_to_back();
        test_xor16();
        test_short_len();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
